// File: rtl/decode_pkg.sv
// Decoded memory-operation encodings shared between decode, LSU and store buffer.
package decode_pkg;

    typedef enum logic [1:0] {
        LSU_SB = 2'd0,
        LSU_SH = 2'd1,
        LSU_SW = 2'd2
    } lsu_op_e;

endpackage

// File: rtl/global_config_pkg.sv
// Core-wide configuration record shared by every block that needs XLEN/PLEN.
package global_config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned PLEN;
    } cfg_t;

    localparam cfg_t Cfg = '{XLEN: 32, PLEN: 32};

endpackage

// File: rtl/store_buffer_pkg.sv
// Store-buffer entry layout; fields are sized to the widest supported config and
// each instance uses only the low XLEN/PLEN/ROB_IDX_WIDTH bits.
package store_buffer_pkg;

    import decode_pkg::*;

    localparam int unsigned SB_ROB_W_MAX = 16;
    localparam int unsigned SB_PLEN_MAX  = 64;
    localparam int unsigned SB_XLEN_MAX  = 64;

    typedef struct packed {
        logic [SB_ROB_W_MAX-1:0] rob_idx;
        logic [SB_PLEN_MAX-1:0]  addr;
        logic [SB_XLEN_MAX-1:0]  data;
        lsu_op_e                 op;
        logic                    exec;
        logic                    committed;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_select.sv
// Store-to-load forwarding search: picks the youngest older executed store to the same word.
// Purely combinational; an older store with unknown address or a partial-width match forces conflict.
module sb_fwd_select
    import decode_pkg::*;
    import store_buffer_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned PLEN          = 32,
    parameter int unsigned ROB_IDX_WIDTH = 6,
    parameter int unsigned SB_DEPTH      = 16,
    localparam int unsigned SB_IDX_WIDTH = $clog2(SB_DEPTH)
) (
    input  logic [SB_DEPTH-1:0]      valid,
    input  sb_entry_t                entries [SB_DEPTH],
    input  logic [ROB_IDX_WIDTH-1:0] rob_head,
    input  logic [ROB_IDX_WIDTH-1:0] load_rob_idx,
    input  logic [PLEN-1:0]          load_addr,
    output logic                     hit,
    output logic                     conflict,
    output logic [XLEN-1:0]          data
);

    logic [ROB_IDX_WIDTH-1:0] load_age;
    logic [ROB_IDX_WIDTH-1:0] entry_age;
    logic [ROB_IDX_WIDTH-1:0] best_age;
    logic [SB_IDX_WIDTH-1:0]  best_idx;
    logic                     found;
    logic                     unknown;
    logic                     unused_bits;

    // Ages are distances from the ROB head, so wrap of the tag space is harmless.
    always_comb begin
        load_age  = load_rob_idx - rob_head;
        entry_age = '0;
        best_age  = '0;
        best_idx  = '0;
        found     = 1'b0;
        unknown   = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            entry_age = entries[i].rob_idx[ROB_IDX_WIDTH-1:0] - rob_head;
            if (valid[i] && (entry_age < load_age)) begin
                if (!entries[i].exec) begin
                    unknown = 1'b1;
                end else if ((entries[i].addr[PLEN-1:2] == load_addr[PLEN-1:2]) &&
                             (!found || (entry_age > best_age))) begin
                    found    = 1'b1;
                    best_age = entry_age;
                    best_idx = SB_IDX_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        hit      = 1'b0;
        conflict = 1'b0;
        data     = '0;
        if (unknown) begin
            conflict = 1'b1;
        end else if (found) begin
            if (entries[best_idx].op == LSU_SW) begin
                hit  = 1'b1;
                data = entries[best_idx].data[XLEN-1:0];
            end else begin
                conflict = 1'b1;
            end
        end
    end

    always_comb begin
        unused_bits = ^load_addr[1:0];
        for (int i = 0; i < SB_DEPTH; i++) begin
            unused_bits = unused_bits ^ (^entries[i]);
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: alloc at dispatch, fill at execute, commit from ROB, drain to dcache.
// Drain request is registered state only; st_req holds while st_req_ready_i is low.
module store_buffer
    import decode_pkg::*;
    import store_buffer_pkg::*;
#(
    parameter global_config_pkg::cfg_t Cfg = global_config_pkg::Cfg,
    parameter int unsigned ROB_IDX_WIDTH   = 6,
    parameter int unsigned SB_DEPTH        = 16,
    localparam int unsigned SB_IDX_WIDTH   = $clog2(SB_DEPTH),
    localparam int unsigned XLEN           = Cfg.XLEN,
    localparam int unsigned PLEN           = Cfg.PLEN
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    input  logic [ROB_IDX_WIDTH-1:0] alloc_rob_idx_i,
    output logic [SB_IDX_WIDTH-1:0]  alloc_sb_id_o,
    input  logic                     sb_ex_valid_i,
    input  logic [SB_IDX_WIDTH-1:0]  sb_ex_sb_id_i,
    input  logic [PLEN-1:0]          sb_ex_addr_i,
    input  logic [XLEN-1:0]          sb_ex_data_i,
    input  lsu_op_e                  sb_ex_op_i,
    input  logic                     commit_i,
    input  logic [ROB_IDX_WIDTH-1:0] rob_head_i,
    input  logic [PLEN-1:0]          sb_load_addr_i,
    input  logic [ROB_IDX_WIDTH-1:0] sb_load_rob_idx_i,
    output logic                     sb_load_hit_o,
    output logic [XLEN-1:0]          sb_load_data_o,
    output logic                     sb_load_conflict_o,
    output logic                     st_req_valid_o,
    input  logic                     st_req_ready_i,
    output logic [PLEN-1:0]          st_req_addr_o,
    output logic [XLEN-1:0]          st_req_data_o,
    output lsu_op_e                  st_req_op_o,
    output logic                     empty_o
);

    sb_entry_t               entries_q [SB_DEPTH];
    logic [SB_DEPTH-1:0]     valid_q;
    logic [SB_IDX_WIDTH:0]   head_q, commit_q, tail_q, commit_next;
    logic [SB_IDX_WIDTH-1:0] head_idx, commit_idx, tail_idx;
    logic                    full, head_vld;
    logic                    alloc_fire, ex_fire, commit_fire, drain_fire;

    assign head_idx    = head_q[SB_IDX_WIDTH-1:0];
    assign commit_idx  = commit_q[SB_IDX_WIDTH-1:0];
    assign tail_idx    = tail_q[SB_IDX_WIDTH-1:0];
    assign full        = (head_idx == tail_idx) && (head_q[SB_IDX_WIDTH] != tail_q[SB_IDX_WIDTH]);
    assign head_vld    = valid_q[head_idx] && entries_q[head_idx].committed;

    // Space freed by a drain is only visible next cycle because full uses registered head.
    assign alloc_fire  = alloc_valid_i && !full && !flush_i;
    assign ex_fire     = sb_ex_valid_i && valid_q[sb_ex_sb_id_i];
    assign commit_fire = commit_i && (commit_q != tail_q);
    assign drain_fire  = head_vld && st_req_ready_i;
    assign commit_next = commit_q + (SB_IDX_WIDTH+1)'(commit_fire);

    assign alloc_ready_o  = !full;
    assign alloc_sb_id_o  = tail_idx;
    assign empty_o        = (head_q == tail_q);
    assign st_req_valid_o = head_vld;
    assign st_req_addr_o  = head_vld ? entries_q[head_idx].addr[PLEN-1:0] : '0;
    assign st_req_data_o  = head_vld ? entries_q[head_idx].data[XLEN-1:0] : '0;
    assign st_req_op_o    = head_vld ? entries_q[head_idx].op : LSU_SB;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
            valid_q  <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                entries_q[i].exec      <= 1'b0;
                entries_q[i].committed <= 1'b0;
            end
        end else begin
            if (alloc_fire) begin
                valid_q[tail_idx]             <= 1'b1;
                entries_q[tail_idx].rob_idx   <= SB_ROB_W_MAX'(alloc_rob_idx_i);
                entries_q[tail_idx].exec      <= 1'b0;
                entries_q[tail_idx].committed <= 1'b0;
            end
            if (ex_fire) begin
                entries_q[sb_ex_sb_id_i].addr <= SB_PLEN_MAX'(sb_ex_addr_i);
                entries_q[sb_ex_sb_id_i].data <= SB_XLEN_MAX'(sb_ex_data_i);
                entries_q[sb_ex_sb_id_i].op   <= sb_ex_op_i;
                entries_q[sb_ex_sb_id_i].exec <= 1'b1;
            end
            if (commit_fire) begin
                entries_q[commit_idx].committed <= 1'b1;
            end
            if (drain_fire) begin
                valid_q[head_idx]             <= 1'b0;
                entries_q[head_idx].exec      <= 1'b0;
                entries_q[head_idx].committed <= 1'b0;
            end
            // Flush keeps anything committed, including an entry committing this very cycle.
            if (flush_i) begin
                for (int i = 0; i < SB_DEPTH; i++) begin
                    if (!entries_q[i].committed &&
                        !(commit_fire && (SB_IDX_WIDTH'(i) == commit_idx))) begin
                        valid_q[i]        <= 1'b0;
                        entries_q[i].exec <= 1'b0;
                    end
                end
            end
            head_q   <= head_q + (SB_IDX_WIDTH+1)'(drain_fire);
            commit_q <= commit_next;
            tail_q   <= flush_i ? commit_next : tail_q + (SB_IDX_WIDTH+1)'(alloc_fire);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (sb_ex_valid_i) begin
                assert (valid_q[sb_ex_sb_id_i])
                else $error("store_buffer: execute write to free entry %0d", sb_ex_sb_id_i);
            end
            if (commit_i) begin
                assert ((commit_q != tail_q) &&
                        (entries_q[commit_idx].exec || (ex_fire && (sb_ex_sb_id_i == commit_idx))))
                else $error("store_buffer: commit of unexecuted entry %0d", commit_idx);
            end
        end
    end

    sb_fwd_select #(
        .XLEN          (XLEN),
        .PLEN          (PLEN),
        .ROB_IDX_WIDTH (ROB_IDX_WIDTH),
        .SB_DEPTH      (SB_DEPTH)
    ) u_fwd (
        .valid        (valid_q),
        .entries      (entries_q),
        .rob_head     (rob_head_i),
        .load_rob_idx (sb_load_rob_idx_i),
        .load_addr    (sb_load_addr_i),
        .hit          (sb_load_hit_o),
        .conflict     (sb_load_conflict_o),
        .data         (sb_load_data_o)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drained stores are checked against a scoreboard queue.
module tb_store_buffer;
    import decode_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni, flush_i, alloc_valid_i, alloc_ready_o;
    logic [5:0]  alloc_rob_idx_i, rob_head_i, sb_load_rob_idx_i;
    logic [3:0]  alloc_sb_id_o, sb_ex_sb_id_i;
    logic        sb_ex_valid_i, commit_i;
    logic [31:0] sb_ex_addr_i, sb_ex_data_i, sb_load_addr_i, sb_load_data_o;
    lsu_op_e     sb_ex_op_i, st_req_op_o;
    logic        sb_load_hit_o, sb_load_conflict_o, st_req_valid_o, st_req_ready_i, empty_o;
    logic [31:0] st_req_addr_o, st_req_data_o;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        lsu_op_e     op;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   drains = 0;
    int   drains_before;
    logic [31:0] probe [3];

    always #5 clk_i = ~clk_i;

    store_buffer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_rob_idx_i(alloc_rob_idx_i), .alloc_sb_id_o(alloc_sb_id_o),
        .sb_ex_valid_i(sb_ex_valid_i), .sb_ex_sb_id_i(sb_ex_sb_id_i),
        .sb_ex_addr_i(sb_ex_addr_i), .sb_ex_data_i(sb_ex_data_i), .sb_ex_op_i(sb_ex_op_i),
        .commit_i(commit_i), .rob_head_i(rob_head_i),
        .sb_load_addr_i(sb_load_addr_i), .sb_load_rob_idx_i(sb_load_rob_idx_i),
        .sb_load_hit_o(sb_load_hit_o), .sb_load_data_o(sb_load_data_o),
        .sb_load_conflict_o(sb_load_conflict_o),
        .st_req_valid_o(st_req_valid_o), .st_req_ready_i(st_req_ready_i),
        .st_req_addr_o(st_req_addr_o), .st_req_data_o(st_req_data_o),
        .st_req_op_o(st_req_op_o), .empty_o(empty_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scores any drain happening at the coming edge, then advances one cycle.
    task automatic step();
        exp_t e;
        if (st_req_valid_o && st_req_ready_i) begin
            drains++;
            check("st_req_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("st_req_addr", st_req_addr_o, e.addr);
                check("st_req_data", st_req_data_o, e.data);
                check("st_req_op", st_req_op_o, e.op);
            end
        end
        @(posedge clk_i);
        #1;
        alloc_valid_i = 1'b0;
        sb_ex_valid_i = 1'b0;
        commit_i      = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic alloc(input logic [5:0] rob);
        alloc_valid_i   = 1'b1;
        alloc_rob_idx_i = rob;
        step();
    endtask

    task automatic ex(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                      input lsu_op_e op);
        sb_ex_valid_i = 1'b1;
        sb_ex_sb_id_i = id;
        sb_ex_addr_i  = addr;
        sb_ex_data_i  = data;
        sb_ex_op_i    = op;
        step();
    endtask

    task automatic commit_store(input logic [31:0] addr, input logic [31:0] data, input lsu_op_e op);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.op   = op;
        exp_q.push_back(e);
        commit_i = 1'b1;
        step();
    endtask

    task automatic load(input logic [31:0] addr, input logic [5:0] rob, input string tag,
                        input logic hit, input logic conflict, input logic [31:0] data);
        sb_load_addr_i    = addr;
        sb_load_rob_idx_i = rob;
        #1;
        check({tag, "_hit"}, sb_load_hit_o, hit);
        check({tag, "_conflict"}, sb_load_conflict_o, conflict);
        check({tag, "_data"}, sb_load_data_o, data);
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; alloc_valid_i = 1'b0; alloc_rob_idx_i = '0;
        sb_ex_valid_i = 1'b0; sb_ex_sb_id_i = '0; sb_ex_addr_i = '0; sb_ex_data_i = '0;
        sb_ex_op_i = LSU_SB; commit_i = 1'b0; rob_head_i = '0; sb_load_addr_i = '0;
        sb_load_rob_idx_i = '0; st_req_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_alloc_ready", alloc_ready_o, 1);
        check("rst_empty", empty_o, 1);
        check("rst_alloc_id", alloc_sb_id_o, 0);
        check("rst_st_valid", st_req_valid_o, 0);
        check("rst_st_addr", st_req_addr_o, 0);
        check("rst_hit", sb_load_hit_o, 0);
        check("rst_conflict", sb_load_conflict_o, 0);
        rst_ni = 1'b1;

        // Fill all 16 entries without draining.
        for (int i = 0; i < 16; i++) begin
            check("fill_alloc_id", alloc_sb_id_o, 64'(i));
            alloc(6'(i));
        end
        check("full_ready", alloc_ready_o, 0);
        check("full_not_empty", empty_o, 0);

        probe[0] = 32'h8000_0010;
        probe[1] = 32'h0000_1234;
        probe[2] = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) load(probe[i], 6'd20, "unknown_addr", 1'b0, 1'b1, 32'h0);

        ex(4'd0, 32'h8000_0100, 32'hCAFE_F00D, LSU_SW);
        commit_store(32'h8000_0100, 32'hCAFE_F00D, LSU_SW);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", st_req_valid_o, 1);
            check("bp_addr", st_req_addr_o, 32'h8000_0100);
            check("bp_data", st_req_data_o, 32'hCAFE_F00D);
            step();
        end
        st_req_ready_i = 1'b1;
        drains_before = drains;
        step();
        check("bp_single_fire", 64'(drains - drains_before), 1);
        check("bp_valid_drop", st_req_valid_o, 0);
        check("wrap_ready", alloc_ready_o, 1);
        check("wrap_alloc_id", alloc_sb_id_o, 0);
        flush_i = 1'b1;
        step();
        check("fill_flush_empty", empty_o, 1);

        // Forwarding: full-word hit, partial-width conflict, youngest-match selection.
        check("fwd_alloc_id", alloc_sb_id_o, 1);
        alloc(6'd1);
        ex(4'd1, 32'h8000_0010, 32'hDEAD_BEEF, LSU_SW);
        load(32'h8000_0010, 6'd5, "fwd_sw", 1'b1, 1'b0, 32'hDEAD_BEEF);
        load(32'h8000_0014, 6'd5, "fwd_other_word", 1'b0, 1'b0, 32'h0);
        load(32'h8000_0010, 6'd1, "fwd_same_age", 1'b0, 1'b0, 32'h0);
        alloc(6'd2);
        ex(4'd2, 32'h8000_0011, 32'h0000_00AA, LSU_SB);
        load(32'h8000_0010, 6'd5, "partial_sb", 1'b0, 1'b1, 32'h0);
        load(32'h8000_0010, 6'd2, "older_than_sb", 1'b1, 1'b0, 32'hDEAD_BEEF);
        alloc(6'd3);
        ex(4'd3, 32'h8000_0010, 32'h1234_5678, LSU_SW);
        load(32'h8000_0010, 6'd5, "youngest_sw", 1'b1, 1'b0, 32'h1234_5678);
        commit_store(32'h8000_0010, 32'hDEAD_BEEF, LSU_SW);
        commit_store(32'h8000_0011, 32'h0000_00AA, LSU_SB);
        commit_store(32'h8000_0010, 32'h1234_5678, LSU_SW);
        repeat (4) step();
        check("fwd_drained_empty", empty_o, 1);

        // Flush keeps only the committed store; alloc in the flush cycle is dropped.
        st_req_ready_i = 1'b0;
        drains_before = drains;
        check("flush_alloc_id", alloc_sb_id_o, 4);
        alloc(6'd10);
        alloc(6'd11);
        alloc(6'd12);
        ex(4'd4, 32'h8000_0200, 32'h1111_1111, LSU_SW);
        ex(4'd5, 32'h8000_0204, 32'h2222_2222, LSU_SW);
        ex(4'd6, 32'h8000_0208, 32'h3333_3333, LSU_SH);
        commit_store(32'h8000_0200, 32'h1111_1111, LSU_SW);
        flush_i         = 1'b1;
        alloc_valid_i   = 1'b1;
        alloc_rob_idx_i = 6'd13;
        step();
        st_req_ready_i = 1'b1;
        repeat (6) step();
        check("flush_drain_count", 64'(drains - drains_before), 1);
        check("flush_empty", empty_o, 1);
        check("flush_st_valid", st_req_valid_o, 0);
        check("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
